line_window_buffer: RTL
=======================

# line_window_buffer

Parametrised streaming line buffer for the video pipeline. It holds TAPS+1 line memories in a rotating ring and, for every incoming pixel at column x of line y, outputs the vertically aligned column x of lines y-1 … y-TAPS together with the delayed current pixel. It sits between the camera or pixel-stream front end and the 2-D window filters (Sobel, Gaussian, median) and replaces the fixed 3-tap, 4-line buffer. It adds frame sync, fill tracking, top-border handling and line-length protection.

## Interface
- DATA_W, 24: pixel width in bits.
- X_W, 11: column address width; maximum line length is 2^X_W pixels.
- TAPS, 3: number of previous-line outputs, legal range 2..8; TAPS+1 physical line memories.
- CLK  in  1: single pixel clock; all logic and RAM ports run on its rising edge.
- RESET  in  1: reset, synchronous, active-low.
- IN_VALID  in  1: input pixel qualifier; there is no backpressure.
- IN_SOF  in  1: start of frame, valid with the first pixel of a frame.
- IN_EOL  in  1: end of line, valid with the last pixel of a line.
- IN_DATA  in  DATA_W: input pixel.
- OUT_VALID  out  1: output qualifier.
- OUT_CUR  out  DATA_W: input pixel delayed to align with the taps.
- OUT_TAPS  out  TAPS*DATA_W: tap k occupies bits [k*DATA_W +: DATA_W]; tap 0 is line y-1.
- OUT_EOL  out  1: delayed IN_EOL.
- OUT_FILLED  out  TAPS: bit k=1 means tap k holds real frame data.

## Operation
- Reset values (RESET=0 at a clock edge):
  - outputs: all 0;
  - state: IDLE; wr_line=0, x=0, filled=0.
  - RAM contents are not cleared.
- FSM:
  - IDLE: drop pixels until IN_VALID&IN_SOF, then go to FILL.
  - FILL: filled<TAPS.
  - RUN: filled==TAPS.
  - IN_VALID&IN_SOF in any state restarts the frame: x=0, wr_line=0, filled=0, state FILL. That same pixel is written at column 0.
- Write path, per accepted pixel:
  - write IN_DATA to ram[wr_line][x], then x++.
  - If x has reached 2^X_W-1, x saturates and further writes in that line are suppressed until IN_EOL.
- On IN_EOL:
  - x=0;
  - wr_line=(wr_line+1) mod (TAPS+1), using explicit compare-and-wrap, not natural binary wrap;
  - filled=min(filled+1, TAPS); reaching TAPS moves FILL to RUN.
- Read path: tap k reads ram[(wr_line-1-k) mod (TAPS+1)][x] at the same address as the write. Read and write never target the same memory.
- OUT_VALID follows every accepted pixel in FILL or RUN, including while filled==0.
- OUT_FILLED bit k = (k < filled), sampled with the pixel.
- Unfilled taps: behaviour is set by the macro (see Configuration).
- IN_EOL and IN_SOF on the same pixel (a one-pixel line): SOF handling is applied first, then the EOL update. Result: filled=1, wr_line=1.

## Timing
- Latency is 2 cycles from IN_VALID to OUT_VALID: one cycle for the RAM read, one for the output register.
- OUT_CUR, OUT_EOL and OUT_FILLED are pipelined to match the taps.
- Throughput: 1 pixel/clock; gaps in IN_VALID are allowed anywhere.
- Ring index and filled updates at EOL take effect from the next pixel. The EOL pixel itself uses the old mapping.
- RESET mid-line: the pipeline is flushed. OUT_VALID=0 on the cycle after the reset edge and stays 0 until the next SOF pixel has passed through the pipe.

## Configuration
- LWB_BORDER_REPLICATE_EN defined: an unfilled tap k outputs the value of the highest filled tap (filled-1) at that column. If filled==0, every tap outputs OUT_CUR's pixel.
- Not defined: unfilled taps output 0.
- OUT_FILLED is identical in both builds.

## Structure
- Package line_window_pkg holds:
  - the FSM state enum (IDLE, FILL, RUN);
  - a ring-index width function clog2(TAPS+1);
  - a tap-slice helper constant.
- Sub-module line_ram: simple dual-port, DATA_W x 2^X_W, write-first not required, 1-cycle registered read. It is instantiated TAPS+1 times with a generate loop.
- The top level holds the FSM, counters, read-index decode, border mux and output registers.

## Test plan
All scenarios use TAPS=3, X_W=4, DATA_W=8 unless stated.
- Reset: hold RESET=0 for 3 clocks -> all outputs 0, OUT_VALID=0; pixels without SOF are then ignored.
- Fill: SOF, then lines of 4 pixels with value 16*line+x -> on line 3, pixel 2: OUT_CUR=0x32, taps = 0x22, 0x12, 0x02, OUT_FILLED=3'b111, 2 cycles after input.
- Border, line 1 pixel 1, OUT_FILLED=3'b001:
  - with macro: taps = 0x01, 0x01, 0x01;
  - without macro: taps = 0x01, 0x00, 0x00.
- Ring wrap: 10 lines -> on line 9, taps show lines 8, 7, 6 (0x8x, 0x7x, 0x6x); no stale data from wrapped memories.
- Overlong line: 20 pixels before EOL with X_W=4 -> columns 0..15 stored, pixels 16..19 dropped, next line reads columns 0..15 correctly.
- Mid-frame SOF and mid-line RESET:
  - SOF at line 5, pixel 2 -> OUT_FILLED returns to 0;
  - RESET at line 2, pixel 1 -> OUT_VALID low until 2 cycles after the next SOF.

Source files
------------

// File: rtl/line_window_buffer_pkg.sv
// Shared types and elaboration helpers for the line_window_buffer slice.
// Holds the sequencing state enum, ring-index width and tap-slice position helpers.
package line_window_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } lwb_state_e;

  // The width must hold both a ring index (0..TAPS) and the fill count (0..TAPS).
  function automatic int ring_w(input int taps);
    return $clog2(taps + 1);
  endfunction

  function automatic int tap_lsb(input int k, input int data_w);
    return k * data_w;
  endfunction

endpackage

// File: rtl/line_window_buffer_if.sv
// Pixel stream in / aligned window column out for line_window_buffer.
// master drives the input stream and consumes the window; slave is the buffer.
interface line_window_buffer_if #(
  parameter int DATA_W = 24,
  parameter int TAPS   = 3
) ();
  logic                     IN_VALID;
  logic                     IN_SOF;
  logic                     IN_EOL;
  logic [DATA_W-1:0]        IN_DATA;
  logic                     OUT_VALID;
  logic [DATA_W-1:0]        OUT_CUR;
  logic [TAPS*DATA_W-1:0]   OUT_TAPS;
  logic                     OUT_EOL;
  logic [TAPS-1:0]          OUT_FILLED;

  modport master (
    output IN_VALID, IN_SOF, IN_EOL, IN_DATA,
    input  OUT_VALID, OUT_CUR, OUT_TAPS, OUT_EOL, OUT_FILLED
  );

  modport slave (
    input  IN_VALID, IN_SOF, IN_EOL, IN_DATA,
    output OUT_VALID, OUT_CUR, OUT_TAPS, OUT_EOL, OUT_FILLED
  );
endinterface

// File: rtl/line_window_buffer_line_ram.sv
// One line memory: simple dual-port, DATA_W x 2^ADDR_W, registered read.
// Contents are never cleared; the read register holds when re_i is low.
module line_ram #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 11
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] wa_i,
  input  logic [DATA_W-1:0] wd_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] ra_i,
  output logic [DATA_W-1:0] rd_o
);
  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rd_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[wa_i] <= wd_i;
    if (re_i) rd_q <= mem_q[ra_i];
  end

  assign rd_o = rd_q;
endmodule

// File: rtl/line_window_buffer.sv
// Rotating TAPS+1 line buffer giving vertically aligned columns for 2-D window filters.
// Build macro LWB_BORDER_REPLICATE_EN: unfilled taps replicate the nearest filled line.
//
// state | meaning
// IDLE  | no frame yet, pixels dropped until an SOF pixel
// FILL  | frame running, fewer than TAPS previous lines held
// RUN   | frame running, every tap holds a real line
module line_window_buffer
  import line_window_pkg::*;
#(
  parameter int DATA_W = 24,
  parameter int X_W    = 11,
  parameter int TAPS   = 3
) (
  input logic                CLK,
  input logic                RESET,
  line_window_buffer_if.slave bus
);
  localparam int                NLINES = TAPS + 1;
  localparam int                RING_W = ring_w(TAPS);
  localparam logic [RING_W-1:0] TAPS_R = RING_W'(TAPS);
  localparam logic [X_W-1:0]    X_MAX  = '1;

  lwb_state_e        state_q, state_d;
  logic [RING_W-1:0] wr_line_q, wr_line_d;
  logic [RING_W-1:0] filled_q, filled_d;
  logic [X_W-1:0]    x_q, x_d;
  logic              full_q, full_d;

  logic              sof, accept, wr_en;
  logic [RING_W-1:0] line_eff, filled_eff;
  logic [X_W-1:0]    x_eff;
  logic              full_eff;

  logic              v1_q, eol1_q;
  logic [DATA_W-1:0] cur1_q;
  logic [RING_W-1:0] filled1_q, line1_q;

  logic                   out_valid_q, out_eol_q;
  logic [DATA_W-1:0]      out_cur_q;
  logic [TAPS*DATA_W-1:0] out_taps_q, out_taps_d;
  logic [TAPS-1:0]        out_filled_q, out_filled_d;

  logic [DATA_W-1:0] ram_rd  [NLINES];
  logic [DATA_W-1:0] tap_raw [TAPS];

  // An SOF pixel sees a freshly restarted frame before its own write and EOL update.
  always_comb begin
    sof        = bus.IN_VALID & bus.IN_SOF;
    accept     = bus.IN_VALID & ((state_q != IDLE) | bus.IN_SOF);
    line_eff   = sof ? '0 : wr_line_q;
    filled_eff = sof ? '0 : filled_q;
    x_eff      = sof ? '0 : x_q;
    full_eff   = sof ? 1'b0 : full_q;
    wr_en      = accept & ~full_eff;

    state_d   = state_q;
    wr_line_d = wr_line_q;
    filled_d  = filled_q;
    x_d       = x_q;
    full_d    = full_q;
    if (accept) begin
      wr_line_d = line_eff;
      filled_d  = filled_eff;
      x_d       = x_eff;
      full_d    = full_eff;
      if (bus.IN_EOL) begin
        x_d       = '0;
        full_d    = 1'b0;
        wr_line_d = (line_eff == TAPS_R) ? '0 : line_eff + RING_W'(1);
        filled_d  = (filled_eff == TAPS_R) ? filled_eff : filled_eff + RING_W'(1);
      end else if (x_eff == X_MAX) begin
        full_d = 1'b1;
      end else begin
        x_d = x_eff + X_W'(1);
      end
      state_d = (filled_d == TAPS_R) ? RUN : FILL;
    end
  end

  for (genvar i = 0; i < NLINES; i++) begin : g_line
    line_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (X_W)
    ) u_line_ram (
      .clk_i (CLK),
      .we_i  (wr_en && (line_eff == RING_W'(i))),
      .wa_i  (x_eff),
      .wd_i  (bus.IN_DATA),
      .re_i  (accept),
      .ra_i  (x_eff),
      .rd_o  (ram_rd[i])
    );
  end

  // Tap k lives in line (wr_line - 1 - k) mod NLINES, i.e. wr_line + TAPS - k wrapped once.
  always_comb begin : p_tap_sel
    logic [RING_W:0]   sum;
    logic [RING_W-1:0] idx;
    sum = '0;
    idx = '0;
    for (int k = 0; k < TAPS; k++) begin
      sum = {1'b0, line1_q} + (RING_W+1)'(TAPS - k);
      if (sum >= (RING_W+1)'(NLINES)) sum = sum - (RING_W+1)'(NLINES);
      idx = sum[RING_W-1:0];
      tap_raw[k] = ram_rd[idx];
    end
  end

`ifdef LWB_BORDER_REPLICATE_EN
  logic [DATA_W-1:0] edge_pix;
`endif

  always_comb begin
    out_taps_d   = '0;
    out_filled_d = '0;
`ifdef LWB_BORDER_REPLICATE_EN
    edge_pix = cur1_q;
`endif
    for (int k = 0; k < TAPS; k++) begin
      if (RING_W'(k) < filled1_q) begin
        out_filled_d[k] = 1'b1;
        out_taps_d[tap_lsb(k, DATA_W) +: DATA_W] = tap_raw[k];
`ifdef LWB_BORDER_REPLICATE_EN
        edge_pix = tap_raw[k];
`endif
      end
`ifdef LWB_BORDER_REPLICATE_EN
      else begin
        out_taps_d[tap_lsb(k, DATA_W) +: DATA_W] = edge_pix;
      end
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q      <= IDLE;
      wr_line_q    <= '0;
      filled_q     <= '0;
      x_q          <= '0;
      full_q       <= 1'b0;
      v1_q         <= 1'b0;
      eol1_q       <= 1'b0;
      cur1_q       <= '0;
      filled1_q    <= '0;
      line1_q      <= '0;
      out_valid_q  <= 1'b0;
      out_eol_q    <= 1'b0;
      out_cur_q    <= '0;
      out_taps_q   <= '0;
      out_filled_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_line_q <= wr_line_d;
      filled_q  <= filled_d;
      x_q       <= x_d;
      full_q    <= full_d;
      v1_q      <= accept;
      if (accept) begin
        eol1_q    <= bus.IN_EOL;
        cur1_q    <= bus.IN_DATA;
        filled1_q <= filled_eff;
        line1_q   <= line_eff;
      end
      out_valid_q <= v1_q;
      out_eol_q   <= v1_q & eol1_q;
      if (v1_q) begin
        out_cur_q    <= cur1_q;
        out_taps_q   <= out_taps_d;
        out_filled_q <= out_filled_d;
      end
    end
  end

  assign bus.OUT_VALID  = out_valid_q;
  assign bus.OUT_CUR    = out_cur_q;
  assign bus.OUT_TAPS   = out_taps_q;
  assign bus.OUT_EOL    = out_eol_q;
  assign bus.OUT_FILLED = out_filled_q;
endmodule
